// File: rtl/tile_accum_ctrl_if.sv
// tile_accum_ctrl_if -- signal bundle between the tile accumulation controller
// and its surroundings (activation producer, tile FIFO, accumulator).
//
//   start            job request (sampled only while the controller is idle)
//   num_input_tiles  tiles in the requested job
//   act_valid        producer has a packed activation tile ready
//   act_load         FIFO push strobe / producer accept
//   fifo_full        tile FIFO cannot take another tile
//   fifo_empty       tile FIFO has nothing to pop
//   fifo_read        FIFO pop strobe; popped data is valid the next cycle
//   acc_clear        accumulator clear pulse at the start of a job
//   acc_en           accumulator consumes the FIFO output tile this cycle
//   busy             controller is working on a job
//   done             one-cycle job-complete pulse
//   err              one-cycle pulse on a rejected start
//   tile_count       tiles accumulated in the current/last job
//
// master: the surroundings (drives requests and FIFO status)
// slave:  the controller
interface tile_accum_ctrl_if;
  logic       start;
  logic [3:0] num_input_tiles;
  logic       act_valid;
  logic       act_load;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_read;
  logic       acc_clear;
  logic       acc_en;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] tile_count;

  modport master (
    output start, num_input_tiles, act_valid, fifo_full, fifo_empty,
    input  act_load, fifo_read, acc_clear, acc_en, busy, done, err, tile_count
  );

  modport slave (
    input  start, num_input_tiles, act_valid, fifo_full, fifo_empty,
    output act_load, fifo_read, acc_clear, acc_en, busy, done, err, tile_count
  );
endinterface

// File: rtl/tile_accum_ctrl.sv
// tile_accum_ctrl -- sequences one accumulation job over a 16-lane systolic
// array: collect N activation tiles into the tile FIFO, feed them back out
// into the accumulator, wait for the array to flush, then pulse done.
//
// Ports:
//   clk    single clock, all state changes on the rising edge
//   reset  asynchronous, active-high
//   bus    tile_accum_ctrl_if.slave (see the interface file for signals)
//
// Parameters:
//   MAX_INPUT_TILES  tile FIFO depth and largest accepted job (<= 15)
//   DRAIN_CYCLES     array flush latency in cycles (>= 1)
module tile_accum_ctrl #(
  parameter int MAX_INPUT_TILES = 4,
  parameter int DRAIN_CYCLES    = 31
) (
  input  logic              clk,
  input  logic              reset,
  tile_accum_ctrl_if.slave  bus
);

  localparam int         DW    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [3:0] MAX_N = 4'(MAX_INPUT_TILES);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    FEED,
    DRAIN,
    DONE
  } state_t;

  state_t        state, state_nxt;
  logic [3:0]    n_q;          // tiles in the accepted job
  logic [3:0]    push_cnt;
  logic [3:0]    read_cnt;
  logic [3:0]    tile_cnt;
  logic [DW-1:0] drain_cnt;
  logic          acc_clear_q;
  logic          acc_en_q;
  logic          err_q;

  logic          n_legal;
  logic          accept;
  logic          reject;
  logic          act_load_c;
  logic          fifo_read_c;

  assign n_legal = (bus.num_input_tiles != 4'd0) && (bus.num_input_tiles <= MAX_N);
  assign accept  = (state == IDLE) && bus.start &&  n_legal;
  assign reject  = (state == IDLE) && bus.start && !n_legal;

  // NOTE: async reset must appear in the sensitivity list; non-blocking (<=)
  // keeps every register sampling pre-edge values regardless of block order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt   = state;
    act_load_c  = 1'b0;
    fifo_read_c = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) state_nxt = COLLECT;
      end
      COLLECT: begin
        act_load_c = bus.act_valid & ~bus.fifo_full;
        if (act_load_c && (push_cnt == n_q - 4'd1)) state_nxt = FEED;
      end
      FEED: begin
        fifo_read_c = ~bus.fifo_empty && (read_cnt < n_q);
        if (fifo_read_c && (read_cnt == n_q - 4'd1)) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (drain_cnt == DRAIN_LAST) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_q         <= '0;
      push_cnt    <= '0;
      read_cnt    <= '0;
      tile_cnt    <= '0;
      drain_cnt   <= '0;
      acc_clear_q <= 1'b0;
      acc_en_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      // acc_clear lands on the first COLLECT cycle; err on the cycle after a
      // rejected start.
      acc_clear_q <= accept;
      err_q       <= reject;
      // Popped FIFO data is valid one cycle after the read strobe.
      acc_en_q    <= fifo_read_c;

      if (accept) begin
        n_q      <= bus.num_input_tiles;
        push_cnt <= '0;
        read_cnt <= '0;
        tile_cnt <= '0;
      end else begin
        if (act_load_c)  push_cnt <= push_cnt + 4'd1;
        if (fifo_read_c) read_cnt <= read_cnt + 4'd1;
        if (acc_en_q)    tile_cnt <= tile_cnt + 4'd1;
      end

      // Counter is parked at zero until the array starts flushing.
      if (state == DRAIN) drain_cnt <= drain_cnt + DW'(1);
      else                drain_cnt <= '0;
    end
  end

  assign bus.act_load   = act_load_c;
  assign bus.fifo_read  = fifo_read_c;
  assign bus.acc_clear  = acc_clear_q;
  assign bus.acc_en     = acc_en_q;
  assign bus.busy       = (state != IDLE);
  assign bus.done       = (state == DONE);
  assign bus.err        = err_q;
  assign bus.tile_count = tile_cnt;

endmodule

// File: tb/tb_tile_accum_ctrl.sv
// tb_tile_accum_ctrl -- directed bench for tile_accum_ctrl with hand-derived
// cycle-by-cycle expectations. Cycle 0 of each scenario is the cycle in which
// start is presented; inputs are driven 1 ns after the rising edge and outputs
// are sampled on the falling edge.
module tb_tile_accum_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   tests_run    = 0;
  int   tests_failed = 0;
  logic [3:0] last_tc = 4'd0;   // tile_count the model expects to persist

  tile_accum_ctrl_if bus ();

  tile_accum_ctrl #(
    .MAX_INPUT_TILES(4),
    .DRAIN_CYCLES   (31)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic [3:0] n, input logic av,
                       input logic ff, input logic fe);
    bus.start           = s;
    bus.num_input_tiles = n;
    bus.act_valid       = av;
    bus.fifo_full       = ff;
    bus.fifo_empty      = fe;
  endtask

  // {act_load, fifo_read, acc_clear, acc_en, busy, done, err}
  function automatic logic [6:0] flags();
    return {bus.act_load, bus.fifo_read, bus.acc_clear, bus.acc_en,
            bus.busy, bus.done, bus.err};
  endfunction

  task automatic test_reset();
    drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (flags() !== 7'b0 || bus.tile_count !== 4'd0) begin
      tests_failed++;
      $display("FAIL reset_state: got flags=%b tile_count=%0d, expected 0000000 tile_count=0",
               flags(), bus.tile_count);
    end
    reset = 1'b0;   // next scenario starts in this very cycle
  endtask

  task automatic test_nominal();
    logic [6:0] exp_f;
    logic [3:0] exp_tc;
    exp_tc = last_tc;
    for (int c = 0; c <= 38; c++) begin
      drive(c == 0, 4'd2, 1'b1, 1'b0, 1'b0);
      #4;
      exp_f = {c >= 1 && c <= 2, c >= 3 && c <= 4, c == 1, c >= 4 && c <= 5,
               c >= 1 && c <= 36, c == 36, 1'b0};
      tests_run++;
      if (flags() !== exp_f || bus.tile_count !== exp_tc) begin
        tests_failed++;
        $display("FAIL nominal cycle %0d: got flags=%b tile_count=%0d, expected %b tile_count=%0d",
                 c, flags(), bus.tile_count, exp_f, exp_tc);
      end
      if (c == 0) exp_tc = 4'd0;
      else if (exp_f[3]) exp_tc++;
      tick();
    end
    last_tc = exp_tc;
  endtask

  task automatic test_backpressure();
    logic [6:0] exp_f;
    logic [3:0] exp_tc;
    int pushes = 0;
    int done_at = -1;
    exp_tc = last_tc;
    for (int c = 0; c <= 45; c++) begin
      drive(c == 0, 4'd4, 1'b1, c >= 2 && c <= 4, 1'b0);
      #4;
      exp_f = {c == 1 || (c >= 5 && c <= 7), c >= 8 && c <= 11, c == 1,
               c >= 9 && c <= 12, c >= 1 && c <= 43, c == 43, 1'b0};
      tests_run++;
      if (flags() !== exp_f || bus.tile_count !== exp_tc) begin
        tests_failed++;
        $display("FAIL backpressure cycle %0d: got flags=%b tile_count=%0d, expected %b tile_count=%0d",
                 c, flags(), bus.tile_count, exp_f, exp_tc);
      end
      if (bus.act_load === 1'b1) pushes++;
      if (bus.done === 1'b1) done_at = c;
      if (c == 0) exp_tc = 4'd0;
      else if (exp_f[3]) exp_tc++;
      tick();
    end
    tests_run++;
    if (pushes != 4) begin
      tests_failed++;
      $display("FAIL backpressure_push_count: got %0d, expected 4", pushes);
    end
    // unstalled N=4 job finishes in cycle 40
    tests_run++;
    if (done_at != 40 + 3) begin
      tests_failed++;
      $display("FAIL backpressure_done_delay: got done in cycle %0d, expected 43", done_at);
    end
    last_tc = exp_tc;
  endtask

  task automatic test_underflow();
    logic [6:0] exp_f;
    logic [3:0] exp_tc;
    exp_tc = last_tc;
    for (int c = 0; c <= 40; c++) begin
      drive(c == 0, 4'd2, 1'b1, 1'b0, c >= 3 && c <= 4);
      #4;
      exp_f = {c >= 1 && c <= 2, c >= 5 && c <= 6, c == 1, c >= 6 && c <= 7,
               c >= 1 && c <= 38, c == 38, 1'b0};
      tests_run++;
      if (flags() !== exp_f || bus.tile_count !== exp_tc) begin
        tests_failed++;
        $display("FAIL underflow cycle %0d: got flags=%b tile_count=%0d, expected %b tile_count=%0d",
                 c, flags(), bus.tile_count, exp_f, exp_tc);
      end
      if (c == 0) exp_tc = 4'd0;
      else if (exp_f[3]) exp_tc++;
      tick();
    end
    tests_run++;
    if (bus.tile_count !== 4'd2) begin
      tests_failed++;
      $display("FAIL underflow_tile_count: got %0d, expected 2", bus.tile_count);
    end
    last_tc = exp_tc;
  endtask

  task automatic test_illegal_count();
    logic [6:0] exp_f;
    for (int c = 0; c <= 5; c++) begin
      // act_valid / fifo status wiggle while idle and must do nothing
      drive(c == 0 || c == 2, (c == 2) ? 4'd5 : 4'd0, c[0], c[1], ~c[0]);
      #4;
      exp_f = {6'b0, c == 1 || c == 3};
      tests_run++;
      if (flags() !== exp_f || bus.tile_count !== last_tc) begin
        tests_failed++;
        $display("FAIL illegal_count cycle %0d: got flags=%b tile_count=%0d, expected %b tile_count=%0d",
                 c, flags(), bus.tile_count, exp_f, last_tc);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_feed();
    logic [6:0] exp_f;
    logic [3:0] exp_tc;
    exp_tc = last_tc;
    for (int c = 0; c <= 5; c++) begin
      drive(c == 0, 4'd3, 1'b1, 1'b0, 1'b0);
      #4;
      exp_f = {c >= 1 && c <= 3, c >= 4, c == 1, c >= 5, c >= 1, 1'b0, 1'b0};
      tests_run++;
      if (flags() !== exp_f || bus.tile_count !== exp_tc) begin
        tests_failed++;
        $display("FAIL reset_mid_feed cycle %0d: got flags=%b tile_count=%0d, expected %b tile_count=%0d",
                 c, flags(), bus.tile_count, exp_f, exp_tc);
      end
      if (c == 0) exp_tc = 4'd0;
      if (c < 5) tick();
    end
    // Second read in flight, first tile entering the accumulator: reset now.
    #1 reset = 1'b1;
    #1;
    tests_run++;
    if (flags() !== 7'b0 || bus.tile_count !== 4'd0) begin
      tests_failed++;
      $display("FAIL reset_async: got flags=%b tile_count=%0d, expected 0000000 tile_count=0",
               flags(), bus.tile_count);
    end
    tick();
    reset = 1'b0;
    exp_tc = 4'd0;
    for (int c = 0; c <= 36; c++) begin
      drive(c == 0, 4'd1, 1'b1, 1'b0, 1'b0);
      #4;
      exp_f = {c == 1, c == 2, c == 1, c == 3, c >= 1 && c <= 34, c == 34, 1'b0};
      tests_run++;
      if (flags() !== exp_f || bus.tile_count !== exp_tc) begin
        tests_failed++;
        $display("FAIL after_reset cycle %0d: got flags=%b tile_count=%0d, expected %b tile_count=%0d",
                 c, flags(), bus.tile_count, exp_f, exp_tc);
      end
      if (exp_f[3]) exp_tc++;
      tick();
    end
    last_tc = exp_tc;
  endtask

  task automatic test_start_in_drain();
    logic [6:0] exp_f;
    logic [3:0] exp_tc;
    int dones = 0;
    exp_tc = last_tc;
    for (int c = 0; c <= 37; c++) begin
      // second start (N=2) lands in DRAIN and must neither relatch nor err
      drive(c == 0 || c == 10, (c == 10) ? 4'd2 : 4'd1, 1'b1, 1'b0, 1'b0);
      #4;
      exp_f = {c == 1, c == 2, c == 1, c == 3, c >= 1 && c <= 34, c == 34, 1'b0};
      tests_run++;
      if (flags() !== exp_f || bus.tile_count !== exp_tc) begin
        tests_failed++;
        $display("FAIL start_in_drain cycle %0d: got flags=%b tile_count=%0d, expected %b tile_count=%0d",
                 c, flags(), bus.tile_count, exp_f, exp_tc);
      end
      if (bus.done === 1'b1) dones++;
      if (c == 0) exp_tc = 4'd0;
      else if (exp_f[3]) exp_tc++;
      tick();
    end
    tests_run++;
    if (dones != 1) begin
      tests_failed++;
      $display("FAIL start_in_drain_done_count: got %0d, expected 1", dones);
    end
    last_tc = exp_tc;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_underflow();
    test_illegal_count();
    test_reset_mid_feed();
    test_start_in_drain();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/tile_accum_ctrl.md
TILE_ACCUM_CTRL -- requirements
Module: tile_accum_ctrl

Interface
REQ-001 Parameter MAX_INPUT_TILES, default 4: tile FIFO depth; upper bound on tiles per job.
REQ-002 Parameter DRAIN_CYCLES, default 31: systolic array flush latency in cycles, 2*16-1 for the 16-lane array.
REQ-003 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port start, input, 1: job request, sampled only in IDLE.
REQ-006 Port num_input_tiles, input, 4: tiles per job, latched on accepted start.
REQ-007 Port act_valid, input, 1: producer has a packed activation tile ready.
REQ-008 Port act_load, output, 1: FIFO push strobe / producer accept.
REQ-009 Port fifo_full, input, 1 and fifo_empty, input, 1: tile FIFO status.
REQ-010 Port fifo_read, output, 1: FIFO pop strobe; FIFO data is valid the following cycle.
REQ-011 Port acc_clear, output, 1: accumulator clear pulse.
REQ-012 Port acc_en, output, 1: accumulator accepts FIFO output tile this cycle.
REQ-013 Port busy, output, 1: high in every state except IDLE.
REQ-014 Port done, output, 1: one-cycle job-complete pulse.
REQ-015 Port err, output, 1: one-cycle pulse on a rejected start.
REQ-016 Port tile_count, output, 4: tiles popped in the current job.

Function
REQ-017 FSM states SHALL be IDLE, COLLECT, FEED, DRAIN, DONE; state register and counters are internal.
REQ-018 IDLE: start=1 with 1 <= num_input_tiles <= MAX_INPUT_TILES -> COLLECT next cycle, N latched, push/read counters and tile_count zeroed.
REQ-019 IDLE: start=1 with num_input_tiles = 0 or > MAX_INPUT_TILES -> err=1 for the next cycle only; stay IDLE.
REQ-020 acc_clear SHALL be high exactly during the first cycle in COLLECT.
REQ-021 COLLECT: act_load = act_valid & ~fifo_full (combinational); each act_load increments the push count; after the Nth push, go to FEED next cycle.
REQ-022 act_load SHALL be 0 in every state except COLLECT.
REQ-023 FEED: fifo_read = ~fifo_empty while read count < N; fifo_empty stalls without advancing.
REQ-024 acc_en SHALL be fifo_read delayed by one cycle (registered).
REQ-025 tile_count SHALL increment on the cycle acc_en is high.
REQ-026 After the Nth fifo_read, go to DRAIN next cycle; the final acc_en occurs in the first DRAIN cycle.
REQ-027 DRAIN SHALL last exactly DRAIN_CYCLES cycles with fifo_read=0, then go to DONE.
REQ-028 DONE SHALL last one cycle with done=1, then return to IDLE; tile_count holds N until the next accepted start.
REQ-029 start outside IDLE SHALL be ignored: no err, no relatch.
REQ-030 act_valid or fifo status changes outside COLLECT/FEED SHALL have no effect.
REQ-031 Counters SHALL be 4 bits wide; N <= MAX_INPUT_TILES ensures no wrap.

Reset
REQ-032 reset=1 SHALL asynchronously force IDLE, all counters to 0, and all outputs to 0 (act_load, fifo_read, acc_clear, acc_en, busy, done, err, tile_count).
REQ-033 Reset asserted mid-job SHALL abandon the job with no done pulse; the FIFO shares the same reset, so no stale tiles remain.
REQ-034 The first start is accepted in the first cycle after reset deasserts.

Verification
REQ-035 Nominal: start at cycle 0, N=2, act_valid=1, no full/empty stalls -> act_load in cycles 1-2; fifo_read in 3-4; acc_en in 4-5; DRAIN 5-35; done=1 in cycle 36; tile_count=2; busy 1-36.
REQ-036 Backpressure: N=4, fifo_full=1 in cycles 2-4 -> act_load=0 in cycles 2-4; exactly 4 pushes total; done delayed by 3 cycles relative to the unstalled case.
REQ-037 Underflow stall: fifo_empty=1 for 2 FEED cycles -> fifo_read=0 and acc_en=0 in the matching cycles; tile_count still ends at N.
REQ-038 Illegal count: start with N=0, then start with N=5 -> err pulse each, busy stays 0, no acc_clear.
REQ-039 Reset mid-FEED after 1 of 3 reads -> all outputs 0 immediately (asynchronously); next start with N=1 completes normally with tile_count=1.
REQ-040 start pulsed during DRAIN -> ignored; exactly one done pulse for the job.
